// File: rtl/fir_sample_writer.sv
// FIR sample history writer: accepts samples into a circular RAM and serves lagged reads.
// Optional flush port is enabled by defining SAMPLE_FLUSH_EN.
module fir_sample_writer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1000,
    parameter int LAG_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
`ifdef SAMPLE_FLUSH_EN
    input  logic              flush,
`endif
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              new_sample,
    output logic [ADDR_W-1:0] sample_idx,
    input  logic              proc_done,
    input  logic              rd_req,
    input  logic [LAG_W-1:0]  rd_lag,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    typedef enum logic [1:0] {INIT, IDLE, PEND} state_t;

    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH-1);

    state_t            state_q;
    logic              s_ready_q;
    logic              new_sample_q;
    logic [ADDR_W-1:0] sample_idx_q;
    logic [ADDR_W-1:0] acc_q;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] last_ptr_q;
    logic [ADDR_W:0]   fill_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              flush_w;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_ptr_d;
    logic [ADDR_W:0]   fill_d;
    logic [ADDR_W:0]   lag_x;
    logic [ADDR_W:0]   last_x;
    logic [ADDR_W:0]   rd_addr_d;
    logic [DATA_W-1:0] rd_data_d;

`ifdef SAMPLE_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    assign wr_en    = (state_q == IDLE) && s_valid && !flush_w;
    assign wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
    assign fill_d   = (fill_q == DEPTH_X) ? fill_q : fill_q + 1'b1;

    // Lag is subtracted modulo DEPTH, which need not be a power of two
    assign lag_x     = {{(ADDR_W+1-LAG_W){1'b0}}, rd_lag};
    assign last_x    = {1'b0, last_ptr_q};
    assign rd_addr_d = (lag_x > last_x) ? last_x + DEPTH_X - lag_x
                                        : last_x - lag_x;
    assign rd_data_d = (lag_x >= fill_q) ? '0
                                         : mem[rd_addr_d[ADDR_W-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= s_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= INIT;
            s_ready_q    <= 1'b0;
            new_sample_q <= 1'b0;
            sample_idx_q <= '0;
            acc_q        <= '0;
            wr_ptr_q     <= '0;
            last_ptr_q   <= '0;
            fill_q       <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
        end else if (flush_w) begin
            state_q      <= IDLE;
            s_ready_q    <= 1'b1;
            new_sample_q <= 1'b0;
            sample_idx_q <= '0;
            acc_q        <= '0;
            wr_ptr_q     <= '0;
            last_ptr_q   <= '0;
            fill_q       <= '0;
            rd_valid_q   <= 1'b0;
        end else begin
            rd_valid_q <= rd_req;
            if (rd_req) begin
                rd_data_q <= rd_data_d;
            end
            case (state_q)
                INIT: begin
                    state_q   <= IDLE;
                    s_ready_q <= 1'b1;
                end
                IDLE: begin
                    if (s_valid) begin
                        last_ptr_q   <= wr_ptr_q;
                        wr_ptr_q     <= wr_ptr_d;
                        fill_q       <= fill_d;
                        sample_idx_q <= acc_q;
                        acc_q        <= acc_q + 1'b1;
                        state_q      <= PEND;
                        s_ready_q    <= 1'b0;
                        new_sample_q <= 1'b1;
                    end
                end
                PEND: begin
                    if (proc_done) begin
                        state_q      <= IDLE;
                        s_ready_q    <= 1'b1;
                        new_sample_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= INIT;
                    s_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready    = s_ready_q;
    assign new_sample = new_sample_q;
    assign sample_idx = sample_idx_q;
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;

endmodule
